// File: rtl/dcm_lock_supervisor_pkg.sv
// Shared definitions for the DCM lock supervisor: state encoding and timer sizing.
package dcm_sup_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    // One timer serves every timed state, so it is sized for the longest interval.
    function automatic int timer_width(int rst_cycles, int lock_timeout, int settle_cycles);
        int m;
        m = rst_cycles;
        if (lock_timeout > m) m = lock_timeout;
        if (settle_cycles > m) m = settle_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/dcm_lock_supervisor_if.sv
// DCM control/status bundle between the supervisor (master) and the DCM primitive (slave).
// Plain level signals, no valid/ready: dcm_rst is a registered level, dcm_locked and
// dcm_clkin_stopped are asynchronous levels that the master resynchronises before use.
interface dcm_lock_supervisor_if;
    logic dcm_rst;
    logic dcm_locked;
    logic dcm_clkin_stopped;

    modport master (output dcm_rst, input dcm_locked, input dcm_clkin_stopped);
    modport slave  (input dcm_rst, output dcm_locked, output dcm_clkin_stopped);
endinterface

// File: rtl/dcm_lock_supervisor_sync2.sv
// Generic two-flop synchronizer for a single asynchronous level.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff <= 2'b00;
        end else begin
            r_ff <= {r_ff[0], i_d};
        end
    end

    assign o_q = r_ff[1];
endmodule

// File: rtl/dcm_lock_supervisor.sv
// Sequences the DCM reset, waits for and qualifies LOCKED, and raises clk_ready only
// after a clean settle window; re-sequences automatically on lock loss or CLKIN stop.
module dcm_lock_supervisor
    import dcm_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic                  clkin,
    input  logic                  rst_n,
    input  logic                  enable,
    dcm_lock_supervisor_if.master dcm,
    output logic                  clk_ready,
    output logic                  fault,
    output logic [CNT_W-1:0]      relock_count,
    output logic [2:0]            state
);
    localparam int TW = timer_width(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    state_e           r_state;
    logic [TW-1:0]    r_timer;
    logic [RW-1:0]    r_retry;
    logic [CNT_W-1:0] r_relock;
    logic             r_dcm_rst;
    logic             r_clk_ready;
    logic             r_fault;

    logic          w_locked_s;
    logic          w_stopped_s;
    logic          w_lost;
    logic [RW-1:0] w_retry_inc;
    logic          w_retry_exhausted;

    sync2 u_sync_locked (
        .clk   (clkin),
        .rst_n (rst_n),
        .i_d   (dcm.dcm_locked),
        .o_q   (w_locked_s)
    );

    sync2 u_sync_stopped (
        .clk   (clkin),
        .rst_n (rst_n),
        .i_d   (dcm.dcm_clkin_stopped),
        .o_q   (w_stopped_s)
    );

    assign w_lost            = !w_locked_s || w_stopped_s;
    assign w_retry_inc       = r_retry + RW'(1);
    assign w_retry_exhausted = (w_retry_inc == RW'(MAX_RETRIES));

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_retry     <= '0;
            r_relock    <= '0;
            r_dcm_rst   <= 1'b1;
            r_clk_ready <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_timer <= r_timer + TW'(1);
            if (!enable) begin
                r_state     <= ST_IDLE;
                r_timer     <= '0;
                r_retry     <= '0;
                r_dcm_rst   <= 1'b1;
                r_clk_ready <= 1'b0;
                r_fault     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_RESET;
                        r_timer <= '0;
                    end
                    ST_RESET: begin
                        if (r_timer == TW'(RST_CYCLES - 1)) begin
                            r_state   <= ST_WAIT_LOCK;
                            r_timer   <= '0;
                            r_dcm_rst <= 1'b0;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        // Lock is tested first so it wins over a coincident timeout.
                        if (w_locked_s) begin
                            r_state <= ST_SETTLE;
                            r_timer <= '0;
                        end else if (r_timer == TW'(LOCK_TIMEOUT - 1)) begin
                            r_retry   <= w_retry_inc;
                            r_timer   <= '0;
                            r_dcm_rst <= 1'b1;
                            if (w_retry_exhausted) begin
                                r_state <= ST_FAULT;
                                r_fault <= 1'b1;
                            end else begin
                                r_state <= ST_RESET;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (w_lost) begin
                            r_retry   <= w_retry_inc;
                            r_timer   <= '0;
                            r_dcm_rst <= 1'b1;
                            if (w_retry_exhausted) begin
                                r_state <= ST_FAULT;
                                r_fault <= 1'b1;
                            end else begin
                                r_state <= ST_RESET;
                            end
                        end else if (r_timer == TW'(SETTLE_CYCLES - 1)) begin
                            r_state     <= ST_RUN;
                            r_timer     <= '0;
                            r_retry     <= '0;
                            r_clk_ready <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (w_lost) begin
                            r_state     <= ST_RESET;
                            r_timer     <= '0;
                            r_dcm_rst   <= 1'b1;
                            r_clk_ready <= 1'b0;
                            if (r_relock != '1) r_relock <= r_relock + CNT_W'(1);
                        end
                    end
                    ST_FAULT: begin
                        r_dcm_rst   <= 1'b1;
                        r_clk_ready <= 1'b0;
                        r_fault     <= 1'b1;
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_timer     <= '0;
                        r_dcm_rst   <= 1'b1;
                        r_clk_ready <= 1'b0;
                        r_fault     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dcm.dcm_rst   = r_dcm_rst;
    assign clk_ready     = r_clk_ready;
    assign fault         = r_fault;
    assign relock_count  = r_relock;
    assign state         = r_state;
endmodule

// File: doc/dcm_lock_supervisor.md
Name: dcm_lock_supervisor

Overview:
Sequences and supervises the x5 CLKFX multiplier DCM. It drives the DCM reset with a guaranteed minimum pulse and waits for LOCKED with a timeout. It then qualifies lock over a settle window before raising clk_ready, and re-sequences the DCM automatically on lock loss or input-clock stop. It runs on the raw input clock, upstream of all logic clocked by the DCM output, and replaces direct use of the raw LOCKED pin as a ready flag.

Parameters:
RST_CYCLES, 8, cycles dcm_rst is held high per reset pulse (min 3 per DCM datasheet)
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before a retry
SETTLE_CYCLES, 1024, consecutive locked cycles required before clk_ready
MAX_RETRIES, 4, consecutive failed attempts before FAULT
CNT_W, 8, width of relock_count

Ports:
clkin  in  1  raw reference clock, also the DCM CLKIN source
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = bring up and maintain DCM; 0 = hold DCM in reset
dcm_locked  in  1  DCM LOCKED_OUT
dcm_clkin_stopped  in  1  DCM STATUS[1] (CLKIN stopped)
dcm_rst  out  1  active-high DCM RST
clk_ready  out  1  DCM output clock qualified stable
fault  out  1  MAX_RETRIES consecutive failures
relock_count  out  CNT_W  lock losses detected in RUN, saturating
state  out  3  current FSM state encoding

Behaviour:
- dcm_locked and dcm_clkin_stopped pass through a 2-flop synchronizer (locked_s, stopped_s). All decisions use the synchronized values, which adds 2 cycles of latency.
- Reset values (async, rst_n=0): state=IDLE, dcm_rst=1, clk_ready=0, fault=0, relock_count=0, retry=0, timer=0, sync flops=0.
- One shared timer of width clog2(max(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES))+1. It clears on every state entry.
- States and encodings: IDLE=0, RESET=1, WAIT_LOCK=2, SETTLE=3, RUN=4, FAULT=5.
- IDLE: dcm_rst=1. If enable=1, go to RESET next cycle.
- RESET: dcm_rst=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK. dcm_rst falls on the first WAIT_LOCK cycle.
- WAIT_LOCK: dcm_rst=0.
  - locked_s=1: go to SETTLE.
  - Otherwise, when timer reaches LOCK_TIMEOUT-1: retry+1. If the new retry equals MAX_RETRIES, go to FAULT; else go to RESET.
  - Lock and timeout in the same cycle: lock wins.
- SETTLE: dcm_rst=0.
  - locked_s must remain 1 for SETTLE_CYCLES consecutive cycles, then go to RUN and clear retry to 0.
  - If locked_s=0 or stopped_s=1 during the window: retry+1, with the same FAULT/RESET rule as WAIT_LOCK.
- RUN: clk_ready=1 (registered; asserted from the first RUN cycle).
  - locked_s=0 or stopped_s=1: go to RESET, relock_count+1 (saturates at all-ones).
  - clk_ready drops in the same cycle the state leaves RUN.
- FAULT: fault=1, dcm_rst=1, clk_ready=0. The FSM stays in FAULT while enable=1.
- enable=0 has top priority in every state. The next state is IDLE, and retry and fault clear. relock_count is kept; only rst_n clears it.
- A glitch on dcm_locked shorter than 1 clkin cycle may be missed. This is acceptable because real lock loss is a sustained deassertion.
- rst_n asserted mid-operation returns all outputs to their reset values immediately (asynchronously). Release of rst_n is synchronous to clkin by the system reset bridge.

Decomposition:
- Package dcm_sup_pkg: state encoding constants/enum (3 bits), and a function computing the timer width from the parameters.
- Sub-module sync2: a generic 2-flop synchronizer with the same rst_n. It is instantiated twice, for dcm_locked and dcm_clkin_stopped.
- The FSM, timer and counters stay in dcm_lock_supervisor.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=32, SETTLE_CYCLES=16, MAX_RETRIES=3.
1. Nominal bring-up: enable=1; dcm_locked rises 10 cycles after dcm_rst falls -> dcm_rst high exactly 4 cycles; clk_ready rises 2+1+16 cycles after dcm_locked; fault=0; relock_count=0.
2. Lock timeout: dcm_locked held 0 -> exactly 3 RESET pulses of 4 cycles, spaced by 32-cycle WAIT_LOCK windows; then state=5, fault=1, dcm_rst=1. Driving enable=0 then 1 -> fault clears and a new RESET pulse starts.
3. Settle failure: dcm_locked goes high, then drops at settle cycle 8 -> RESET re-entered, retry=1, clk_ready never asserted. Then a stable lock -> RUN, with retry back to 0.
4. Lock loss in RUN: dcm_locked drops for 5 cycles -> clk_ready falls 3 cycles after the drop; relock_count=1; re-lock completes. Repeating 300 times -> relock_count saturates at 255.
5. CLKIN stopped: dcm_clkin_stopped pulses high for 3 cycles in RUN while dcm_locked stays 1 -> RESET entered, relock_count increments.
6. Async reset mid-SETTLE: rst_n pulsed low for a half cycle -> outputs go to dcm_rst=1, clk_ready=0, relock_count=0 immediately, state=IDLE.
